// File: rtl/mem_req_arbiter.sv
// Grants the shared SDRAM controller port to the I-cache or the D-cache for one line burst.
// Tie policy is round-robin unless MEM_ARB_FIXED_PRIO_EN is defined, which makes the D-cache win every tie.
module mem_req_arbiter #(
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_req_valid,
  input  logic [ADDR_WIDTH-1:0]         i_req_addr,
  output logic                          i_req_ready,
  output logic                          i_rsp_valid,
  output logic                          i_rsp_last,
  output logic [DATA_WIDTH-1:0]         i_rsp_data,
  input  logic                          d_req_valid,
  input  logic                          d_req_we,
  input  logic [ADDR_WIDTH-1:0]         d_req_addr,
  output logic                          d_req_ready,
  input  logic [DATA_WIDTH-1:0]         d_wdata,
  input  logic                          d_wdata_valid,
  output logic                          d_wdata_ready,
  output logic                          d_rsp_valid,
  output logic                          d_rsp_last,
  output logic [DATA_WIDTH-1:0]         d_rsp_data,
  output logic                          m_req_valid,
  output logic                          m_req_we,
  output logic [ADDR_WIDTH-1:0]         m_req_addr,
  input  logic                          m_req_ready,
  output logic                          m_wdata_valid,
  output logic [DATA_WIDTH-1:0]         m_wdata,
  input  logic                          m_wdata_ready,
  input  logic                          m_rsp_valid,
  input  logic [DATA_WIDTH-1:0]         m_rsp_data,
  output logic [1:0]                    owner,
  output logic [1:0]                    dbg_state,
  output logic [$clog2(BURST_LEN)-1:0]  dbg_beat_cnt
);

  localparam int CW = $clog2(BURST_LEN);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WDATA = 2'd2,
    RDATA = 2'd3
  } state_t;

  state_t                state;
  logic [CW-1:0]         beat_cnt;
  logic                  last_owner_d;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic                  lat_we;
  logic                  grant_d;
  logic                  cmd_hs;
  logic                  wr_hs;
  logic                  rd_beat;
  logic                  burst_end;

  // A transfer happens on a rising edge where valid and ready are both high;
  // valid never waits on ready, and the requester holds its payload until then.
  always_comb begin
    grant_d = 1'b0;
`ifdef MEM_ARB_FIXED_PRIO_EN
    grant_d = d_req_valid;
`else
    grant_d = d_req_valid && (!i_req_valid || !last_owner_d);
`endif
  end

  assign cmd_hs    = (state == ISSUE) && m_req_ready;
  assign wr_hs     = (state == WDATA) && d_wdata_valid && m_wdata_ready;
  assign rd_beat   = (state == RDATA) && m_rsp_valid;
  assign burst_end = (wr_hs || rd_beat) && (beat_cnt == LAST_BEAT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      owner        <= 2'b00;
      last_owner_d <= 1'b1;
      beat_cnt     <= '0;
      lat_addr     <= '0;
      lat_we       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req_valid || d_req_valid) begin
            state <= ISSUE;
            if (grant_d) begin
              owner    <= 2'b10;
              lat_addr <= d_req_addr;
              lat_we   <= d_req_we;
            end else begin
              owner    <= 2'b01;
              lat_addr <= i_req_addr;
              lat_we   <= 1'b0;
            end
          end
        end
        ISSUE: begin
          if (m_req_ready) begin
            state    <= lat_we ? WDATA : RDATA;
            beat_cnt <= '0;
          end
        end
        WDATA, RDATA: begin
          if (wr_hs || rd_beat) beat_cnt <= beat_cnt + CW'(1);
          if (burst_end) begin
            state        <= IDLE;
            owner        <= 2'b00;
            last_owner_d <= owner[1];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Everything below is a gated passthrough so a mid-burst reset silences all outputs at once.
  assign m_req_valid   = (state == ISSUE);
  assign m_req_addr    = lat_addr;
  assign m_req_we      = lat_we;
  assign i_req_ready   = cmd_hs && owner[0];
  assign d_req_ready   = cmd_hs && owner[1];

  assign m_wdata_valid = (state == WDATA) && d_wdata_valid;
  assign m_wdata       = (state == WDATA) ? d_wdata : '0;
  assign d_wdata_ready = (state == WDATA) && m_wdata_ready;

  assign i_rsp_valid   = rd_beat && owner[0];
  assign i_rsp_data    = i_rsp_valid ? m_rsp_data : '0;
  assign i_rsp_last    = i_rsp_valid && (beat_cnt == LAST_BEAT);
  assign d_rsp_valid   = rd_beat && owner[1];
  assign d_rsp_data    = d_rsp_valid ? m_rsp_data : '0;
  assign d_rsp_last    = d_rsp_valid && (beat_cnt == LAST_BEAT);

  assign dbg_state     = state;
  assign dbg_beat_cnt  = beat_cnt;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: directed scenarios plus randomized bursts
// checked against a grant-order model and a data scoreboard.
module tb_mem_req_arbiter;

  localparam int AW = 26;
  localparam int DW = 32;
  localparam int BL = 4;
  localparam logic [1:0] OWN_I   = 2'b01;
  localparam logic [1:0] OWN_D   = 2'b10;
  localparam logic [1:0] ST_IDLE = 2'd0;
`ifdef MEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED_PRIO = 1'b1;
`else
  localparam bit FIXED_PRIO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_req_valid, i_req_ready, i_rsp_valid, i_rsp_last;
  logic [AW-1:0] i_req_addr;
  logic [DW-1:0] i_rsp_data;
  logic          d_req_valid, d_req_we, d_req_ready, d_wdata_valid, d_wdata_ready;
  logic          d_rsp_valid, d_rsp_last;
  logic [AW-1:0] d_req_addr;
  logic [DW-1:0] d_wdata, d_rsp_data;
  logic          m_req_valid, m_req_we, m_req_ready, m_wdata_valid, m_wdata_ready, m_rsp_valid;
  logic [AW-1:0] m_req_addr;
  logic [DW-1:0] m_wdata, m_rsp_data;
  logic [1:0]    owner, dbg_state;
  logic [1:0]    dbg_beat_cnt;

  int            checks;
  int            errors;
  bit            model_last_d;
  logic [DW-1:0] exp_q[$];

  mem_req_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
    .i_rsp_valid(i_rsp_valid), .i_rsp_last(i_rsp_last), .i_rsp_data(i_rsp_data),
    .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
    .d_req_ready(d_req_ready), .d_wdata(d_wdata), .d_wdata_valid(d_wdata_valid),
    .d_wdata_ready(d_wdata_ready), .d_rsp_valid(d_rsp_valid), .d_rsp_last(d_rsp_last),
    .d_rsp_data(d_rsp_data), .m_req_valid(m_req_valid), .m_req_we(m_req_we),
    .m_req_addr(m_req_addr), .m_req_ready(m_req_ready), .m_wdata_valid(m_wdata_valid),
    .m_wdata(m_wdata), .m_wdata_ready(m_wdata_ready), .m_rsp_valid(m_rsp_valid),
    .m_rsp_data(m_rsp_data), .owner(owner), .dbg_state(dbg_state), .dbg_beat_cnt(dbg_beat_cnt)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  // reference model: winner of an IDLE decision given which requesters are valid
  function automatic logic [1:0] pick(input logic iv, input logic dv);
    if (iv && dv) return (FIXED_PRIO || !model_last_d) ? OWN_D : OWN_I;
    return dv ? OWN_D : OWN_I;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a;
    a = AW'($urandom);
    a[1:0] = 2'b00;
    return a;
  endfunction

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    i_req_valid = 0; i_req_addr = '0;
    d_req_valid = 0; d_req_we = 0; d_req_addr = '0; d_wdata = '0; d_wdata_valid = 0;
    m_req_ready = 0; m_wdata_ready = 0; m_rsp_valid = 0; m_rsp_data = '0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clear_inputs();
    model_last_d = 1'b1;
    exp_q.delete();
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  // Runs one burst starting in the grant cycle; memory side randomized, data via scoreboard.
  task automatic serve_burst(input logic [1:0] who, input logic [AW-1:0] exp_addr,
                             input logic exp_we, input bit keep_valid);
    int            guard;
    int            beat;
    bit            hs;
    logic          obs_rdy, oth_rdy, obs_v, oth_v, obs_last;
    logic [DW-1:0] obs_data, exp_v;
    checks++;
    if (owner !== who) begin
      errors++; $display("FAIL grant_owner: got %b expected %b", owner, who);
    end
    checks++;
    if (m_req_valid !== 1'b1 || m_req_addr !== exp_addr || m_req_we !== exp_we) begin
      errors++;
      $display("FAIL cmd: valid=%b addr=%h we=%b expected valid=1 addr=%h we=%b",
               m_req_valid, m_req_addr, m_req_we, exp_addr, exp_we);
    end
    hs = 0; guard = 0;
    while (!hs && guard < 50) begin
      m_req_ready = ($urandom_range(0, 2) != 0);
      m_rsp_valid = ($urandom_range(0, 2) == 0);
      m_rsp_data  = $urandom;
      #1;
      obs_rdy = (who == OWN_I) ? i_req_ready : d_req_ready;
      oth_rdy = (who == OWN_I) ? d_req_ready : i_req_ready;
      checks++;
      if (obs_rdy !== m_req_ready || oth_rdy !== 1'b0 || i_rsp_valid !== 1'b0 || d_rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL issue_ready: owner_rdy=%b other_rdy=%b rsp=%b%b expected %b 0 00",
                 obs_rdy, oth_rdy, d_rsp_valid, i_rsp_valid, m_req_ready);
      end
      hs = m_req_ready;
      guard++;
      cyc();
    end
    if (!hs) begin
      checks++; errors++; $display("FAIL issue_timeout: no handshake got 0 expected 1");
    end
    m_req_ready = 0; m_rsp_valid = 0;
    if (!keep_valid) begin
      if (who == OWN_I) i_req_valid = 0;
      else d_req_valid = 0;
    end
    beat = 0; guard = 0;
    while (beat < BL && guard < 200) begin
      guard++;
      if (exp_we) begin
        d_wdata_valid = ($urandom_range(0, 3) != 0);
        d_wdata       = $urandom;
        m_wdata_ready = ($urandom_range(0, 3) != 0);
        m_rsp_valid   = ($urandom_range(0, 2) == 0);
        m_rsp_data    = $urandom;
        if (d_wdata_valid && m_wdata_ready) exp_q.push_back(d_wdata);
        #1;
        checks++;
        if (m_wdata_valid !== d_wdata_valid || d_wdata_ready !== m_wdata_ready ||
            i_rsp_valid !== 1'b0 || d_rsp_valid !== 1'b0) begin
          errors++;
          $display("FAIL wdata_ctl: mwv=%b dwr=%b rsp=%b%b expected %b %b 00",
                   m_wdata_valid, d_wdata_ready, d_rsp_valid, i_rsp_valid, d_wdata_valid, m_wdata_ready);
        end
        if (d_wdata_valid && m_wdata_ready) begin
          exp_v = exp_q.pop_front();
          checks++;
          if (m_wdata !== exp_v) begin
            errors++; $display("FAIL wdata_beat%0d: got %h expected %h", beat, m_wdata, exp_v);
          end
          beat++;
        end
      end else begin
        m_rsp_valid = ($urandom_range(0, 3) != 0);
        m_rsp_data  = $urandom;
        if (m_rsp_valid) exp_q.push_back(m_rsp_data);
        #1;
        obs_v    = (who == OWN_I) ? i_rsp_valid : d_rsp_valid;
        oth_v    = (who == OWN_I) ? d_rsp_valid : i_rsp_valid;
        obs_data = (who == OWN_I) ? i_rsp_data : d_rsp_data;
        obs_last = (who == OWN_I) ? i_rsp_last : d_rsp_last;
        checks++;
        if (obs_v !== m_rsp_valid || oth_v !== 1'b0 || m_wdata_valid !== 1'b0) begin
          errors++;
          $display("FAIL rsp_ctl: owner_v=%b other_v=%b mwv=%b expected %b 0 0",
                   obs_v, oth_v, m_wdata_valid, m_rsp_valid);
        end
        if (m_rsp_valid) begin
          exp_v = exp_q.pop_front();
          checks++;
          if (obs_data !== exp_v || obs_last !== (beat == BL - 1)) begin
            errors++;
            $display("FAIL rsp_beat%0d: data=%h last=%b expected data=%h last=%b",
                     beat, obs_data, obs_last, exp_v, (beat == BL - 1));
          end
          beat++;
        end
      end
      cyc();
    end
    if (beat < BL) begin
      checks++; errors++; $display("FAIL burst_timeout: beats got %0d expected %0d", beat, BL);
    end
    d_wdata_valid = 0; m_wdata_ready = 0; m_rsp_valid = 0;
    #1;
    checks++;
    if (owner !== 2'b00 || dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL bubble: owner=%b state=%0d expected 00 0", owner, dbg_state);
    end
    model_last_d = (who == OWN_D);
  endtask

  // scenarios
  task automatic test_reset();
    clear_inputs();
    model_last_d = 1'b1;
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    #2;
    checks++;
    if (owner !== 0 || m_req_valid !== 0 || m_req_addr !== 0 || m_req_we !== 0 ||
        i_req_ready !== 0 || d_req_ready !== 0 || m_wdata_valid !== 0 || d_wdata_ready !== 0 ||
        i_rsp_valid !== 0 || d_rsp_valid !== 0 || dbg_state !== ST_IDLE || dbg_beat_cnt !== 0) begin
      errors++;
      $display("FAIL reset_outputs: owner=%b mrv=%b addr=%h we=%b state=%0d cnt=%0d expected all 0",
               owner, m_req_valid, m_req_addr, m_req_we, dbg_state, dbg_beat_cnt);
    end
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    #1;
    checks++;
    if (owner !== 0 || m_req_valid !== 0) begin
      errors++; $display("FAIL idle_after_reset: owner=%b mrv=%b expected 00 0", owner, m_req_valid);
    end
  endtask

  task automatic test_i_read();
    logic [DW-1:0] exp_v;
    int            k;
    bit            seen_d;
    i_req_valid = 1; i_req_addr = 26'h100;
    #1;
    checks++;
    if (m_req_valid !== 0 || owner !== 0) begin
      errors++; $display("FAIL pre_grant: mrv=%b owner=%b expected 0 00", m_req_valid, owner);
    end
    cyc();
    checks++;
    if (owner !== OWN_I || m_req_valid !== 1 || m_req_addr !== 26'h100 || m_req_we !== 0) begin
      errors++;
      $display("FAIL i_cmd: owner=%b mrv=%b addr=%h we=%b expected 01 1 100 0",
               owner, m_req_valid, m_req_addr, m_req_we);
    end
    m_req_ready = 1;
    #1;
    checks++;
    if (i_req_ready !== 1 || d_req_ready !== 0) begin
      errors++; $display("FAIL i_ready: i=%b d=%b expected 1 0", i_req_ready, d_req_ready);
    end
    cyc();
    m_req_ready = 0; i_req_valid = 0;
    for (int b = 0; b < BL; b++) exp_q.push_back(32'hA0 + b);
    k = 0; seen_d = 0;
    for (int c = 0; c < 12 && k < BL; c++) begin
      m_rsp_valid = (c % 2 == 0);
      m_rsp_data  = 32'hA0 + k;
      #1;
      if (d_rsp_valid) seen_d = 1;
      checks++;
      if (i_rsp_valid !== m_rsp_valid) begin
        errors++; $display("FAIL i_rsp_valid: got %b expected %b", i_rsp_valid, m_rsp_valid);
      end
      if (m_rsp_valid) begin
        exp_v = exp_q.pop_front();
        checks++;
        if (i_rsp_data !== exp_v || i_rsp_last !== (k == BL - 1)) begin
          errors++;
          $display("FAIL i_rsp_beat%0d: data=%h last=%b expected %h %b", k, i_rsp_data, i_rsp_last, exp_v, (k == BL - 1));
        end
        k++;
      end
      cyc();
    end
    m_rsp_valid = 0;
    #1;
    checks++;
    if (seen_d || owner !== 0 || k !== BL) begin
      errors++; $display("FAIL i_read_end: d_seen=%b owner=%b beats=%0d expected 0 00 %0d", seen_d, owner, k, BL);
    end
    model_last_d = 1'b0;
  endtask

  task automatic test_d_write_stall();
    logic [DW-1:0] wd [BL];
    logic [DW-1:0] exp_v;
    int            b, stall, stall_cycles;
    wd = '{32'h11, 32'h22, 32'h33, 32'h44};
    d_req_valid = 1; d_req_we = 1; d_req_addr = 26'h2000;
    cyc();
    checks++;
    if (owner !== OWN_D || m_req_we !== 1 || m_req_addr !== 26'h2000) begin
      errors++; $display("FAIL d_cmd: owner=%b we=%b addr=%h expected 10 1 2000", owner, m_req_we, m_req_addr);
    end
    m_req_ready = 1;
    #1;
    checks++;
    if (d_req_ready !== 1 || i_req_ready !== 0) begin
      errors++; $display("FAIL d_ready: d=%b i=%b expected 1 0", d_req_ready, i_req_ready);
    end
    cyc();
    m_req_ready = 0; d_req_valid = 0; d_req_we = 0;
    for (int i = 0; i < BL; i++) exp_q.push_back(wd[i]);
    b = 0; stall = 0; stall_cycles = 0;
    for (int c = 0; c < 20 && b < BL; c++) begin
      d_wdata_valid = 1; d_wdata = wd[b];
      m_wdata_ready = !(b == 1 && stall < 3);
      if (b == 1 && stall < 3) stall++;
      #1;
      if (d_wdata_ready === 1'b0) stall_cycles++;
      checks++;
      if (m_wdata_valid !== 1'b1) begin
        errors++; $display("FAIL m_wdata_valid: got %b expected 1", m_wdata_valid);
      end
      if (m_wdata_ready) begin
        exp_v = exp_q.pop_front();
        checks++;
        if (m_wdata !== exp_v) begin
          errors++; $display("FAIL d_wbeat%0d: got %h expected %h", b, m_wdata, exp_v);
        end
        b++;
      end
      cyc();
    end
    d_wdata_valid = 0; m_wdata_ready = 0;
    #1;
    checks++;
    if (stall_cycles !== 3 || b !== BL || owner !== 0) begin
      errors++;
      $display("FAIL d_write_end: stalls=%0d beats=%0d owner=%b expected 3 %0d 00", stall_cycles, b, owner, BL);
    end
    model_last_d = 1'b1;
  endtask

  task automatic test_tie();
    logic [1:0] first, second;
    apply_reset();
    i_req_valid = 1; i_req_addr = 26'h300;
    d_req_valid = 1; d_req_addr = 26'h400; d_req_we = 0;
    first = pick(1'b1, 1'b1);
    cyc();
    serve_burst(first, (first == OWN_I) ? i_req_addr : d_req_addr, 1'b0, 1'b0);
    second = pick(i_req_valid, d_req_valid);
    cyc();
    serve_burst(second, (second == OWN_I) ? i_req_addr : d_req_addr, 1'b0, 1'b0);
  endtask

  task automatic test_alternate();
    logic [1:0] w;
    apply_reset();
    i_req_valid = 1; i_req_addr = rand_addr();
    d_req_valid = 1; d_req_addr = rand_addr(); d_req_we = 1'($urandom_range(0, 1));
    for (int n = 0; n < 4; n++) begin
      w = pick(1'b1, 1'b1);
      cyc();
      serve_burst(w, (w == OWN_I) ? i_req_addr : d_req_addr, (w == OWN_I) ? 1'b0 : d_req_we, 1'b1);
      if (w == OWN_D) d_req_we = 1'($urandom_range(0, 1));
    end
    i_req_valid = 0; d_req_valid = 0;
    cyc();
  endtask

  task automatic test_reset_mid_burst();
    logic [AW-1:0] a;
    i_req_valid = 1; i_req_addr = 26'h500;
    cyc();
    m_req_ready = 1;
    cyc();
    m_req_ready = 0; i_req_valid = 0;
    for (int k = 0; k < 2; k++) begin
      m_rsp_valid = 1; m_rsp_data = $urandom;
      cyc();
    end
    m_rsp_valid = 1; m_rsp_data = 32'hDEAD_BEEF;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (i_rsp_valid !== 0 || i_rsp_data !== 0 || i_rsp_last !== 0 || d_rsp_valid !== 0 ||
        owner !== 0 || m_req_valid !== 0 || m_req_addr !== 0 || m_wdata_valid !== 0 ||
        i_req_ready !== 0 || d_wdata_ready !== 0) begin
      errors++;
      $display("FAIL async_reset: irv=%b ird=%h owner=%b mrv=%b addr=%h expected all 0",
               i_rsp_valid, i_rsp_data, owner, m_req_valid, m_req_addr);
    end
    m_rsp_valid = 0;
    model_last_d = 1'b1;
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    #1;
    checks++;
    if (dbg_state !== ST_IDLE || owner !== 0) begin
      errors++; $display("FAIL idle_after_abort: state=%0d owner=%b expected 0 00", dbg_state, owner);
    end
    a = 26'h540;
    i_req_valid = 1; i_req_addr = a;
    cyc();
    serve_burst(OWN_I, a, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [1:0] w;
    for (int n = 0; n < 16; n++) begin
      if (!i_req_valid && $urandom_range(0, 1) == 1) begin
        i_req_valid = 1; i_req_addr = rand_addr();
      end
      if (!d_req_valid && $urandom_range(0, 1) == 1) begin
        d_req_valid = 1; d_req_addr = rand_addr(); d_req_we = 1'($urandom_range(0, 1));
      end
      if (!i_req_valid && !d_req_valid) begin
        i_req_valid = 1; i_req_addr = rand_addr();
      end
      w = pick(i_req_valid, d_req_valid);
      cyc();
      serve_burst(w, (w == OWN_I) ? i_req_addr : d_req_addr, (w == OWN_I) ? 1'b0 : d_req_we, 1'b0);
    end
    i_req_valid = 0; d_req_valid = 0;
    cyc();
  endtask

  // test sequence and final report
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_i_read();
    test_d_write_stall();
    test_tie();
    test_alternate();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
